slot_round_ctrl: RTL and testbench
==================================

SLOT_ROUND_CTRL -- requirements
Module: slot_round_ctrl

Interface
REQ-001 SHALL have parameter MAX_CREDIT, default 99: credit saturation ceiling, legal range 1..127.
REQ-002 SHALL have parameter PAY_TRIPLE, default 10: credits awarded when all three reels match.
REQ-003 SHALL have parameter PAY_PAIR, default 2: credits awarded when exactly two reels match.
REQ-004 SHALL have parameter SETTLE_CYC, default 4: CLK cycles waited after the third stop before reels are sampled, legal range 1..15.
REQ-005 SHALL have port CLK, input, 1: sole clock; all state updates on its rising edge.
REQ-006 SHALL have port RST, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port C_IN, input, 1: coin level, already synchronous and debounced; each rising edge is one coin.
REQ-008 SHALL have port GAME_START, input, 1: start level; each rising edge is one start request.
REQ-009 SHALL have port SBTN, input, 1: stop-button level; each rising edge is one stop request.
REQ-010 SHALL have ports REEL1, REEL2, REEL3, input, 4 each: current BCD digit (0..9) of each external reel counter.
REQ-011 SHALL have ports STOP1, STOP2, STOP3, output, 1 each: 1 = reel held, 0 = reel spinning.
REQ-012 SHALL have port CREDIT, output, 7: current credit count, binary.
REQ-013 SHALL have port STATE, output, 3: FSM state code, used for LCD page select.
REQ-014 SHALL have port WIN, output, 2: last round result, 00 none, 01 pair, 10 triple.
REQ-015 SHALL have port BUSY, output, 1: 1 while a round is in progress (SPIN, SETTLE, PAYOUT).

Function
REQ-016 SHALL detect rising edges of C_IN, GAME_START and SBTN by comparison with a one-cycle registered copy; an edge acts in the cycle after it appears on the pin.
REQ-017 SHALL implement states IDLE=0, CREDIT=1, SPIN=2, SETTLE=3, PAYOUT=4, driven directly onto STATE; codes 5..7 SHALL recover to IDLE next cycle.
REQ-018 SHALL, in every state, apply each coin edge as credit = min(credit+1, MAX_CREDIT).
REQ-019 IDLE: STOP1..3 = 1; a coin edge SHALL move to CREDIT; GAME_START edges ignored.
REQ-020 CREDIT: a GAME_START edge with credit >= 1 SHALL decrement credit, clear WIN to 00, drive STOP1..3 = 0, zero the stop counter and enter SPIN.
REQ-021 Coin edge and start edge in the same CREDIT cycle SHALL give credit = min(credit+1, MAX_CREDIT) - 1 (99 stays at 98).
REQ-022 SPIN: each SBTN edge SHALL set the STOPn selected by the 2-bit stop counter (0->STOP1, 1->STOP2, 2->STOP3) to 1 and increment the counter; the third stop SHALL enter SETTLE.
REQ-023 SBTN edges outside SPIN SHALL be ignored; GAME_START edges outside CREDIT SHALL be ignored.
REQ-024 SETTLE: SHALL count SETTLE_CYC cycles with STOP1..3 = 1, then enter PAYOUT.
REQ-025 PAYOUT: SHALL last one cycle; triple match sets WIN=10 and adds PAY_TRIPLE; otherwise any pair sets WIN=01 and adds PAY_PAIR; else WIN=00, no add.
REQ-026 PAYOUT credit SHALL be min(credit + pay + coin, MAX_CREDIT), computed at 8 bits before saturation.
REQ-027 After PAYOUT, SHALL enter CREDIT if resulting credit > 0, else IDLE.
REQ-028 WIN SHALL hold its value until the next accepted start or reset.
REQ-029 BUSY SHALL be 1 exactly in SPIN, SETTLE and PAYOUT.

Reset
REQ-030 On RST=1 at a CLK edge SHALL set state IDLE, CREDIT=0, WIN=00, STOP1..3=1, BUSY=0, stop and settle counters 0, and edge-detect registers to 1, so inputs held high through reset create no edge.
REQ-031 RST mid-round SHALL abandon the round with no payout and no credit refund.

Verification
REQ-032 Reset, 3 coin pulses, GAME_START pulse -> CREDIT 3 then 2, STATE 1 then 2, STOP1..3=0, BUSY=1.
REQ-033 In SPIN, 3 SBTN pulses with reels 7,7,7 -> STOP1, STOP2, STOP3 rise in order; after SETTLE_CYC cycles WIN=10, CREDIT += 10, STATE=1.
REQ-034 One coin, start, stops with reels 1,2,3 -> WIN=00, CREDIT=0, STATE=0 (IDLE), BUSY=0.
REQ-035 Credit 99, coin and start edges in same cycle -> CREDIT=98; further coins while 99 -> stays 99.
REQ-036 RST asserted during SETTLE with reels 5,5,2 -> CREDIT=0, WIN=00, STATE=0; SBTN/GAME_START held high across reset generate no action.
REQ-037 Reels 4,9,4 at PAYOUT with coin edge same cycle, credit 0 -> WIN=01, CREDIT=3, STATE=1.

Source files
------------

// File: rtl/slot_round_ctrl.sv
// Slot-machine round controller: coin/credit bookkeeping, three-stop spin
// sequence, settle delay and a one-cycle payout that scores the reel digits.
module slot_round_ctrl #(
    parameter int MAX_CREDIT = 99,
    parameter int PAY_TRIPLE = 10,
    parameter int PAY_PAIR   = 2,
    parameter int SETTLE_CYC = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       C_IN,
    input  logic       GAME_START,
    input  logic       SBTN,
    input  logic [3:0] REEL1,
    input  logic [3:0] REEL2,
    input  logic [3:0] REEL3,
    output logic       STOP1,
    output logic       STOP2,
    output logic       STOP3,
    output logic [6:0] CREDIT,
    output logic [2:0] STATE,
    output logic [1:0] WIN,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CREDIT = 3'd1,
        S_SPIN   = 3'd2,
        S_SETTLE = 3'd3,
        S_PAYOUT = 3'd4
    } state_e;

    localparam logic [7:0] MAX_C8      = 8'(MAX_CREDIT);
    localparam logic [6:0] MAX_C7      = 7'(MAX_CREDIT);
    localparam logic [7:0] PAY_TRIPLE8 = 8'(PAY_TRIPLE);
    localparam logic [7:0] PAY_PAIR8   = 8'(PAY_PAIR);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_e     state_q, state_d;
    logic [6:0] credit_q, credit_d;
    logic [1:0] win_q, win_d;
    logic [2:0] stop_q, stop_d;            // bit 0 drives STOP1
    logic [1:0] stop_cnt_q, stop_cnt_d;
    logic [3:0] settle_cnt_q, settle_cnt_d;
    logic       c_in_q, c_in_d;
    logic       start_q, start_d;
    logic       sbtn_q, sbtn_d;

    logic       coin_edge, start_edge, stop_edge;
    logic       triple, pair;
    logic [7:0] pay;
    logic [7:0] credit_plus_coin;
    logic [7:0] credit_plus_pay;
    logic [6:0] credit_coin_sat;
    logic [6:0] credit_pay_sat;

    function automatic logic [6:0] sat(input logic [7:0] v);
        return (v > MAX_C8) ? MAX_C7 : v[6:0];
    endfunction

    assign coin_edge  = C_IN & ~c_in_q;
    assign start_edge = GAME_START & ~start_q;
    assign stop_edge  = SBTN & ~sbtn_q;

    assign triple = (REEL1 == REEL2) && (REEL2 == REEL3);
    assign pair   = (REEL1 == REEL2) || (REEL2 == REEL3) || (REEL1 == REEL3);
    assign pay    = triple ? PAY_TRIPLE8 : (pair ? PAY_PAIR8 : 8'd0);

    // Payout sum is formed at 8 bits so a 127-credit total cannot wrap before saturation.
    assign credit_plus_coin = {1'b0, credit_q} + {7'd0, coin_edge};
    assign credit_plus_pay  = credit_plus_coin + pay;
    assign credit_coin_sat  = sat(credit_plus_coin);
    assign credit_pay_sat   = sat(credit_plus_pay);

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d      = state_q;
        credit_d     = credit_coin_sat;
        win_d        = win_q;
        stop_d       = stop_q;
        stop_cnt_d   = stop_cnt_q;
        settle_cnt_d = settle_cnt_q;
        c_in_d       = C_IN;
        start_d      = GAME_START;
        sbtn_d       = SBTN;

        case (state_q)
            S_IDLE: begin
                stop_d = 3'b111;
                if (coin_edge) state_d = S_CREDIT;
            end
            S_CREDIT: begin
                if (start_edge && credit_q != 7'd0) begin
                    credit_d   = credit_coin_sat - 7'd1;
                    win_d      = 2'b00;
                    stop_d     = 3'b000;
                    stop_cnt_d = 2'd0;
                    state_d    = S_SPIN;
                end
            end
            S_SPIN: begin
                if (stop_edge) begin
                    case (stop_cnt_q)
                        2'd0:    stop_d[0] = 1'b1;
                        2'd1:    stop_d[1] = 1'b1;
                        default: stop_d[2] = 1'b1;
                    endcase
                    stop_cnt_d = stop_cnt_q + 2'd1;
                    if (stop_cnt_q == 2'd2) begin
                        settle_cnt_d = 4'd0;
                        state_d      = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                stop_d = 3'b111;
                if (settle_cnt_q == SETTLE_LAST) begin
                    settle_cnt_d = 4'd0;
                    state_d      = S_PAYOUT;
                end else begin
                    settle_cnt_d = settle_cnt_q + 4'd1;
                end
            end
            S_PAYOUT: begin
                credit_d = credit_pay_sat;
                win_d    = triple ? 2'b10 : (pair ? 2'b01 : 2'b00);
                state_d  = (credit_pay_sat != 7'd0) ? S_CREDIT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Edge registers reset high so a level already asserted at release is not an edge.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (RST) begin
            state_q      <= S_IDLE;
            credit_q     <= 7'd0;
            win_q        <= 2'b00;
            stop_q       <= 3'b111;
            stop_cnt_q   <= 2'd0;
            settle_cnt_q <= 4'd0;
            c_in_q       <= 1'b1;
            start_q      <= 1'b1;
            sbtn_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            win_q        <= win_d;
            stop_q       <= stop_d;
            stop_cnt_q   <= stop_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            c_in_q       <= c_in_d;
            start_q      <= start_d;
            sbtn_q       <= sbtn_d;
        end
    end

    assign STOP1  = stop_q[0];
    assign STOP2  = stop_q[1];
    assign STOP3  = stop_q[2];
    assign CREDIT = credit_q;
    assign STATE  = state_q;
    assign WIN    = win_q;
    assign BUSY   = (state_q == S_SPIN) || (state_q == S_SETTLE) || (state_q == S_PAYOUT);

endmodule

// File: tb/tb_slot_round_ctrl.sv
// Self-checking bench for slot_round_ctrl: directed scenarios followed by
// random coin/round sequences scored against a transaction-level credit model.
module tb_slot_round_ctrl;

    localparam int MAXC = 99;
    localparam int PT   = 10;
    localparam int PP   = 2;
    localparam int SC   = 4;

    logic       CLK = 1'b0;
    logic       RST;
    logic       C_IN, GAME_START, SBTN;
    logic [3:0] REEL1, REEL2, REEL3;
    logic       STOP1, STOP2, STOP3;
    logic [6:0] CREDIT;
    logic [2:0] STATE;
    logic [1:0] WIN;
    logic       BUSY;

    int total = 0;
    int bad   = 0;
    int m_credit, m_win, m_state;
    int settle_seen, payout_seen;

    slot_round_ctrl #(
        .MAX_CREDIT (MAXC),
        .PAY_TRIPLE (PT),
        .PAY_PAIR   (PP),
        .SETTLE_CYC (SC)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .C_IN       (C_IN),
        .GAME_START (GAME_START),
        .SBTN       (SBTN),
        .REEL1      (REEL1),
        .REEL2      (REEL2),
        .REEL3      (REEL3),
        .STOP1      (STOP1),
        .STOP2      (STOP2),
        .STOP3      (STOP3),
        .CREDIT     (CREDIT),
        .STATE      (STATE),
        .WIN        (WIN),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        total++;
        assert (obs === 32'(exp)) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
        if (STATE == 3'd3) settle_seen++;
        if (STATE == 3'd4) payout_seen++;
    endtask

    task automatic model_coin();
        m_credit = (m_credit + 1 > MAXC) ? MAXC : m_credit + 1;
        if (m_state == 0) m_state = 1;
    endtask

    task automatic model_reset();
        m_credit = 0;
        m_win    = 0;
        m_state  = 0;
    endtask

    task automatic pulse_coin();
        C_IN = 1'b1; tick();
        C_IN = 1'b0; tick();
        model_coin();
    endtask

    task automatic pulse_start();
        GAME_START = 1'b1; tick();
        GAME_START = 1'b0; tick();
    endtask

    task automatic pulse_stop();
        SBTN = 1'b1; tick();
        SBTN = 1'b0; tick();
    endtask

    task automatic do_reset();
        RST = 1'b1; tick(); tick();
        RST = 1'b0; tick();
        model_reset();
    endtask

    task automatic check_status(input string tag);
        check({tag, "_credit"}, CREDIT, m_credit);
        check({tag, "_state"}, STATE, m_state);
        check({tag, "_win"}, WIN, m_win);
    endtask

    // Stops, settle wait and payout scoring for a round already in SPIN.
    task automatic round_tail(input int r1, input int r2, input int r3, input bit coin_mid);
        int pay;
        REEL1 = 4'(r1); REEL2 = 4'(r2); REEL3 = 4'(r3);
        settle_seen = 0;
        payout_seen = 0;
        for (int k = 0; k < 3; k++) begin
            if (coin_mid && k == 1) pulse_coin();
            pulse_stop();
            check("stop_order", {STOP1, STOP2, STOP3}, (7 << (2 - k)) & 7);
        end
        for (int i = 0; i < 40 && BUSY !== 1'b0; i++) tick();
        if (r1 == r2 && r2 == r3) begin
            pay = PT; m_win = 2;
        end else if (r1 == r2 || r2 == r3 || r1 == r3) begin
            pay = PP; m_win = 1;
        end else begin
            pay = 0; m_win = 0;
        end
        m_credit = (m_credit + pay > MAXC) ? MAXC : m_credit + pay;
        m_state  = (m_credit > 0) ? 1 : 0;
        check("round_busy", BUSY, 0);
        check("settle_len", settle_seen, SC);
        check("payout_len", payout_seen, 1);
        check("round_stops", {STOP1, STOP2, STOP3}, 7);
        check_status("round");
    endtask

    task automatic round(input int r1, input int r2, input int r3, input bit coin_mid);
        pulse_start();
        m_credit -= 1;
        m_win    = 0;
        check("spin_state", STATE, 2);
        check("spin_busy", BUSY, 1);
        check("spin_stops", {STOP1, STOP2, STOP3}, 0);
        check("spin_credit", CREDIT, m_credit);
        check("spin_win", WIN, 0);
        round_tail(r1, r2, r3, coin_mid);
    endtask

    initial begin
        int r1, r2, r3, nc;
        RST = 1'b1; C_IN = 1'b0; GAME_START = 1'b0; SBTN = 1'b0;
        REEL1 = 4'd0; REEL2 = 4'd0; REEL3 = 4'd0;
        settle_seen = 0; payout_seen = 0;
        model_reset();

        // Reset values
        tick(); tick();
        RST = 1'b0; tick();
        check_status("reset");
        check("reset_busy", BUSY, 0);
        check("reset_stops", {STOP1, STOP2, STOP3}, 7);

        // Start and stop requests are ignored while idle
        pulse_start();
        pulse_stop();
        check("idle_start_ignored", STATE, 0);
        check("idle_stops", {STOP1, STOP2, STOP3}, 7);

        // Three coins then a start: credit 3 -> 2, CREDIT -> SPIN
        repeat (3) pulse_coin();
        check_status("three_coins");
        pulse_stop();
        check("credit_sbtn_ignored", STATE, 1);
        round(7, 7, 7, 1'b0);

        // One coin, losing reels: back to idle with nothing
        do_reset();
        pulse_coin();
        round(1, 2, 3, 1'b0);
        check("lose_idle_busy", BUSY, 0);

        // Saturation at MAX_CREDIT, then simultaneous coin and start
        repeat (MAXC + 1) pulse_coin();
        check("sat_credit", CREDIT, MAXC);
        C_IN = 1'b1; GAME_START = 1'b1; tick();
        C_IN = 1'b0; GAME_START = 1'b0; tick();
        m_credit = MAXC - 1; m_win = 0;
        check("coin_start_credit", CREDIT, m_credit);
        check("coin_start_state", STATE, 2);
        round_tail(1, 2, 3, 1'b0);
        repeat (3) pulse_coin();
        check("resat_credit", CREDIT, MAXC);

        // Reset during SETTLE with coin/start/stop held high across it
        pulse_start();
        REEL1 = 4'd5; REEL2 = 4'd5; REEL3 = 4'd2;
        pulse_stop(); pulse_stop(); pulse_stop();
        check("pre_reset_settle", STATE, 3);
        C_IN = 1'b1; SBTN = 1'b1; GAME_START = 1'b1;
        do_reset();
        tick(); tick();
        check_status("mid_reset");
        check("mid_reset_busy", BUSY, 0);
        check("mid_reset_stops", {STOP1, STOP2, STOP3}, 7);
        C_IN = 1'b0; tick();
        pulse_coin();
        check_status("held_start_no_edge");
        SBTN = 1'b0; GAME_START = 1'b0; tick();

        // Pair payout with a coin edge in the PAYOUT cycle, credit 0 at payout
        do_reset();
        pulse_coin();
        pulse_start();
        m_credit -= 1;
        REEL1 = 4'd4; REEL2 = 4'd9; REEL3 = 4'd4;
        pulse_stop(); pulse_stop(); pulse_stop();
        for (int i = 0; i < 40 && STATE !== 3'd4; i++) tick();
        check("reach_payout", STATE, 4);
        C_IN = 1'b1; tick();
        C_IN = 1'b0; tick();
        m_credit = 3; m_win = 1; m_state = 1;
        check_status("pair_coin_payout");

        // Random coin and round sequences
        for (int it = 0; it < 20; it++) begin
            nc = int'($urandom_range(0, 3));
            repeat (nc) pulse_coin();
            check_status("rnd_coins");
            if (m_credit == 0) begin
                pulse_start();
                check("rnd_idle_start", STATE, 0);
            end else begin
                r1 = int'($urandom_range(0, 9));
                r2 = ($urandom_range(0, 1) == 0) ? r1 : int'($urandom_range(0, 9));
                r3 = ($urandom_range(0, 2) == 0) ? r1 :
                     (($urandom_range(0, 1) == 0) ? r2 : int'($urandom_range(0, 9)));
                round(r1, r2, r3, 1'($urandom_range(0, 1)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
